// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command/response bytes and
// the frame parity helper used by both the transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        SEND      = 3'd3,
        WAIT_IDLE = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam int         FRAME_BITS   = 11;

    // PS/2 uses odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchronizer, consecutive-sample glitch filter and
// falling-edge detect on the filtered level.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // A new level is accepted only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Idle PS/2 lines are pulled high, so every stage resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, bit shifting
// on device clock falls, acknowledge check and timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [3:0]       edge_next_s;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             clk_level_s, clk_fall_s;
    logic             data_level_s, data_fall_unused;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk     (CLK),
        .rst_n   (RST_N),
        .line_in (PS2_CLK_IN),
        .level   (clk_level_s),
        .fall    (clk_fall_s)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk     (CLK),
        .rst_n   (RST_N),
        .line_in (PS2_DATA_IN),
        .level   (data_level_s),
        .fall    (data_fall_unused)
    );

    assign edge_next_s = edge_cnt_q + 4'd1;

    // Next-state and registered-output logic; one shared counter times every phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d    = INHIBIT;
                    shift_d    = tx_data;
                    parity_d   = odd_parity(tx_data);
                    edge_cnt_d = 4'd0;
                    cnt_d      = '0;
                    clk_oe_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = REQUEST;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQUEST: begin
                // The start bit stays driven until the device's first clock fall.
                if (cnt_q == REQ_LAST) begin
                    state_d  = SEND;
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND, WAIT_IDLE: begin
                // Timeout takes priority over a clock fall in the same cycle.
                if (cnt_q == TO_LAST) begin
                    state_d   = ERR;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == WAIT_IDLE) begin
                        if (clk_level_s && data_level_s) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end else if (clk_fall_s) begin
                        edge_cnt_d = edge_next_s;
                        if (edge_next_s <= 4'd8) begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b0, shift_q[7:1]};
                        end else if (edge_next_s == 4'd9) begin
                            data_oe_d = ~parity_q;
                        end else if (edge_next_s < 4'(FRAME_BITS)) begin
                            data_oe_d = 1'b0;
                        end else begin
                            data_oe_d = 1'b0;
                            if (!data_level_s) begin
                                state_d = WAIT_IDLE;
                            end else begin
                                state_d = ERR;
                                error_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= 4'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural keyboard model clocks frames
// and the observed bits, phase lengths and pulses are compared with expectations.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int P_FILTER = 4;
    localparam int P_INH    = 40;
    localparam int P_REQ    = 12;
    localparam int P_TO     = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dev_clk, dev_data;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, tx_done, tx_error;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
    end

    ps2_host_tx #(
        .INHIBIT_CYCLES (P_INH),
        .REQ_CYCLES     (P_REQ),
        .TIMEOUT_CYCLES (P_TO),
        .FILTER_CYCLES  (P_FILTER)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .PS2_CLK_IN  (ps2_clk_in),
        .PS2_DATA_IN (ps2_data_in),
        .PS2_CLK_OE  (ps2_clk_oe),
        .PS2_DATA_OE (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Keyboard model. Called on the first INHIBIT cycle; measures the inhibit and
    // request phases, then clocks 11 falls, sampling data on each rising edge.
    task automatic run_device(input int half, input bit ack, input bit do_reset,
                              output logic [9:0] bits, output int inh_len, output int req_len);
        bit seen;
        bits = '0; inh_len = 0; req_len = 0; seen = 1'b0;
        for (int n = 0; n < 4 * (P_INH + P_REQ) + 20; n++) begin
            if (ps2_clk_oe && !ps2_data_oe) inh_len++;
            if (ps2_clk_oe && ps2_data_oe)  req_len++;
            if (ps2_clk_in && !ps2_data_in) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("request_seen", seen, 1);
        if (!seen) return;
        repeat (half) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            if (k <= 10) begin
                check("busy_in_frame", busy, 1);
                check("ready_low_in_frame", tx_ready, 0);
                bits[k-1] = ps2_data_in;
            end
            if (do_reset && k == 5) begin
                check("data_oe_before_rst", ps2_data_oe, 1);
                #2 rst_n = 1'b0;
                #1;
                check("clk_oe_async_rst", ps2_clk_oe, 0);
                check("data_oe_async_rst", ps2_data_oe, 0);
                dev_clk = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k == 10 && ack) begin
                repeat (4) @(negedge clk);
                dev_data = 1'b0;
                repeat (half - 4) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int half, input bit ack, input bit do_reset);
        logic [9:0] bits;
        int inh, req, d0, e0;
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        check("ready_before", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("clk_oe_after_accept", ps2_clk_oe, 1);
        run_device(half, ack, do_reset, bits, inh, req);
        check("inhibit_len", inh, P_INH);
        check("request_len", req, P_REQ);
        if (do_reset) begin
            repeat (40) @(negedge clk);
            check("rst_ready", tx_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_data_oe", ps2_data_oe, 0);
            check("rst_no_done", done_cnt - d0, 0);
            check("rst_no_error", err_cnt - e0, 0);
            return;
        end
        check("data_bits", bits[7:0], b);
        check("parity_bit", bits[8], model_parity(b));
        check("stop_bit", bits[9], 1);
        repeat (30) @(negedge clk);
        check("done_count", done_cnt - d0, ack ? 1 : 0);
        check("error_count", err_cnt - e0, ack ? 0 : 1);
        check("ready_after", tx_ready, 1);
        check("clk_oe_after", ps2_clk_oe, 0);
        check("data_oe_after", ps2_data_oe, 0);
    endtask

    initial begin
        logic [9:0] bits;
        int inh, req, d0, cyc;
        bit hit;
        logic prev_doe;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_done", tx_done, 0);
        check("reset_error", tx_error, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(CMD_SET_LEDS, 40, 1'b1, 1'b0);
        send_frame(8'h00, 30, 1'b1, 1'b0);
        send_frame(8'h01, 30, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_frame(8'($urandom), int'($urandom_range(25, 40)), 1'b1, 1'b0);
        end
        send_frame(8'($urandom), 30, 1'b0, 1'b0);

        // Device never clocks: error exactly P_TO cycles after entering SEND.
        @(negedge clk);
        tx_data = 8'($urandom); tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 4 * (P_INH + P_REQ); n++) begin
            if (ps2_clk_in && !ps2_data_in) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to_send_seen", hit, 1);
        cyc = 0; prev_doe = ps2_data_oe; hit = 1'b0;
        for (int n = 0; n < P_TO + 50; n++) begin
            @(negedge clk);
            cyc++;
            if (tx_error) begin
                hit = 1'b1;
                break;
            end
            prev_doe = ps2_data_oe;
        end
        check("to_error_seen", hit, 1);
        check("to_latency", cyc, P_TO);
        check("to_doe_before", prev_doe, 1);
        check("to_doe_at_err", ps2_data_oe, 0);
        check("to_no_done", tx_done, 0);
        repeat (5) @(negedge clk);

        send_frame(8'hE5, 30, 1'b1, 1'b1);
        send_frame(8'($urandom), 30, 1'b1, 1'b0);

        // tx_valid held high across two frames.
        @(negedge clk);
        d0 = done_cnt;
        tx_data = CMD_ECHO; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = CMD_RESET;
        check("b2b_busy_first", busy, 1);
        run_device(35, 1'b1, 1'b0, bits, inh, req);
        check("b2b_first_byte", bits[7:0], CMD_ECHO);
        check("b2b_first_parity", bits[8], model_parity(CMD_ECHO));
        hit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            check("b2b_no_early_ready", tx_ready, tx_done ? 0 : 0);
            if (tx_done) begin
                hit = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", hit, 1);
        @(negedge clk);
        check("b2b_ready_after_done", tx_ready, 1);
        @(negedge clk);
        check("b2b_second_busy", busy, 1);
        check("b2b_second_clk_oe", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        run_device(35, 1'b1, 1'b0, bits, inh, req);
        check("b2b_second_inhibit", inh, P_INH);
        check("b2b_second_byte", bits[7:0], CMD_RESET);
        check("b2b_second_parity", bits[8], model_parity(CMD_RESET));
        repeat (30) @(negedge clk);
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_idle_after", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, echo 0xEE, reset 0xFF, …) from the FPGA to the keyboard over the same two open-drain lines that the keyboard receiver listens on. It runs the full host request sequence: clock inhibit, request-to-send, bit shifting on device clock edges, and acknowledge check. It reports completion or failure to the command logic and tells the receiver when to ignore the lines.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: CLK cycles that PS2_CLK is held low before the request (100 µs at 50 MHz).
- REQ_CYCLES, 100: CLK cycles with clock and data both low before the clock is released.
- TIMEOUT_CYCLES, 750000: maximum CLK cycles from clock release to frame completion (15 ms).
- FILTER_CYCLES, 8: consecutive equal samples needed before a synchronized line level is accepted.

Ports:
- CLK  in  1  system clock, 50 MHz; one clock domain.
- RST_N  in  1  reset, asynchronous and active-low.
- PS2_CLK_IN  in  1  raw PS/2 clock line level.
- PS2_DATA_IN  in  1  raw PS/2 data line level.
- PS2_CLK_OE  out  1  1 = drive PS2_CLK low, 0 = release.
- PS2_DATA_OE  out  1  1 = drive PS2_DATA low, 0 = release.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  1 only in IDLE; a byte is accepted when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE; the receiver discards frames while it is high.
- tx_done  out  1  one-cycle pulse: frame sent and ACK seen.
- tx_error  out  1  one-cycle pulse: bad ACK or timeout.

## Operation
- Input conditioning:
  - Both raw lines pass through a 2-flop synchronizer, then a filter of FILTER_CYCLES samples.
  - fall = filtered clock level was 1 in the previous cycle and is 0 now.
- On accept: latch tx_data into a shift register, compute parity = ~^tx_data (odd parity), clear the edge count.
- State machine:
  - IDLE: both OE=0. On accept → INHIBIT.
  - INHIBIT: CLK_OE=1, DATA_OE=0 for INHIBIT_CYCLES → REQUEST.
  - REQUEST: CLK_OE=1, DATA_OE=1 (start bit) for REQ_CYCLES → SEND. Timeout counter cleared.
  - SEND: CLK_OE=0. On each fall, increment edge_cnt (1..11):
    - edges 1–8: DATA_OE = ~tx_data[edge_cnt-1] (LSB first);
    - edge 9: DATA_OE = ~parity;
    - edge 10: DATA_OE=0 (stop bit);
    - edge 11: sample the filtered data line. 0 → WAIT_IDLE. 1 → ERR.
  - WAIT_IDLE: both OE=0. When filtered clock and data are both 1 → DONE.
  - DONE: tx_done=1 for one cycle → IDLE.
  - ERR: both OE=0, tx_error=1 for one cycle → IDLE.
- Timeout:
  - The counter runs in SEND and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES → ERR from either state; lines are released in the same cycle.
- tx_valid while not in IDLE is ignored; there is no queueing.
- Falls seen in IDLE, INHIBIT or REQUEST are ignored.

## Timing
- Reset values: PS2_CLK_OE=0, PS2_DATA_OE=0, tx_done=0, tx_error=0, busy=0, tx_ready=1 (state IDLE).
- RST_N low mid-frame releases both lines immediately (asynchronous) and returns the block to IDLE with no pulse.
- All outputs are registered, except tx_ready and busy, which decode the state register directly.
- Accept edge → PS2_CLK_OE=1 on the next CLK edge.
- Line input → internal fall: 2 sync cycles + FILTER_CYCLES.
- The DATA_OE update for edge k is registered one cycle after fall k. This is well inside the device's ~40 µs low phase.
- The edge counter is 4 bits. Falls after edge 11 in SEND cannot occur because the state leaves SEND on edge 11.
- Fall and timeout expiring in the same cycle: timeout wins → ERR.
- Nominal frame time ≈ 100 µs + 2 µs + 11 × ~80 µs device periods.

## Structure
- Package ps2_pkg holds:
  - state typedef tx_state_t {IDLE, INHIBIT, REQUEST, SEND, WAIT_IDLE, DONE, ERR};
  - constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, RESP_ACK=8'hFA, FRAME_BITS=11.
- The package is shared with the receiver.
- Sub-module ps2_line_filter: synchronizer, filter and fall detect for one line. Instantiated twice here and reusable by the receiver.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that ACKs → the model sees data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; both OE=0 afterwards.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Also check INHIBIT lasts exactly 5000 cycles and REQUEST exactly 100 cycles.
- Device leaves data high on edge 11 (no ACK) → tx_error pulses once, no tx_done, lines released.
- Device never clocks after the request → tx_error exactly 750000 cycles after entering SEND; DATA_OE falls at the same time.
- RST_N pulsed low after edge 5 → both OE drop asynchronously, tx_ready=1 after release, no done/error pulse.
- tx_valid held high with 0xEE then 0xFF across a frame → the second byte is accepted only in the cycle after tx_done; busy is high throughout each frame.
